// File: rtl/uart_sfr_bridge_pkg.sv
// uart_sfr_bridge_pkg: register map and bit positions shared by the bridge and its bench
package uart_sfr_bridge_pkg;
    localparam logic [2:0] ADDR_TXREG   = 3'd0;
    localparam logic [2:0] ADDR_RCREG   = 3'd1;
    localparam logic [2:0] ADDR_STATUS  = 3'd2;
    localparam logic [2:0] ADDR_CTRL    = 3'd3;
    localparam logic [2:0] ADDR_PRESC_L = 3'd4;
    localparam logic [2:0] ADDR_PRESC_H = 3'd5;
    localparam int ST_TXE    = 0;
    localparam int ST_RXA    = 1;
    localparam int ST_RXF    = 2;
    localparam int ST_TXOV   = 3;
    localparam int ST_RXOVR  = 4;
    localparam int ST_FERR   = 5;
    localparam int ST_TXBUSY = 6;
    localparam int CT_TXIE  = 0;
    localparam int CT_RXIE  = 1;
    localparam int CT_ERRIE = 2;
endpackage

// File: rtl/uart_sfr_bridge_rx_fifo.sv
// uart_sfr_bridge_rx_fifo: receive buffer; UART_SFR_BRIDGE_RX_FIFO_EN selects a DEPTH-entry FIFO, else one holding register
module uart_sfr_bridge_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       empty,
    output logic       full,
    output logic       avail_next
);
`ifdef UART_SFR_BRIDGE_RX_FIFO_EN
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] count, count_next;

    assign count_next = count + CW'(push) - CW'(pop);
    assign empty      = count == '0;
    assign full       = count == CW'(DEPTH);
    assign avail_next = count_next != '0;
    assign pop_data   = mem[rp];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            count <= count_next;
        end
    end

    // Storage needs no reset: the count decides what is valid
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= push_data;
    end
`else
    logic [7:0] data;
    logic valid;
    logic [31:0] unused_depth;

    assign unused_depth = 32'(DEPTH);
    assign avail_next   = push || (valid && !pop);
    assign empty        = !valid;
    assign full         = valid;
    assign pop_data     = data;

    // Single holding register; push and pop never coincide since push needs it empty
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= 8'h00;
        end else begin
            valid <= avail_next;
            if (push) data <= push_data;
        end
    end
`endif
endmodule

// File: rtl/uart_sfr_bridge.sv
// uart_sfr_bridge: PIC SFR bus to UART AXI-stream bridge; define UART_SFR_BRIDGE_RX_FIFO_EN for a multi-entry RX FIFO
module uart_sfr_bridge
    import uart_sfr_bridge_pkg::*;
#(
    parameter logic [15:0] PRESCALE_RST  = 16'd2,
    parameter int          RX_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  addr,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        rd_en,
    output logic [7:0]  rd_data,
    output logic        irq,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        tx_busy,
    input  logic        rx_overrun_error,
    input  logic        rx_frame_error,
    output logic [15:0] prescale
);
    logic [2:0] ctrl, ctrl_next;
    logic txov, rxovr, ferr, txov_next, rxovr_next, ferr_next;
    logic hs, wr_tx, tx_accept, tvalid_next;
    logic push, pop, rx_empty, rx_full, rxa_next;
    logic [7:0] rx_data, status, clr, rd_mux;

    assign hs          = m_axis_tvalid && m_axis_tready;
    assign wr_tx       = wr_en && addr == ADDR_TXREG;
    assign tx_accept   = wr_tx && (!m_axis_tvalid || hs);
    assign tvalid_next = tx_accept || (m_axis_tvalid && !hs);
    assign push        = s_axis_tvalid && s_axis_tready;
    assign pop         = rd_en && addr == ADDR_RCREG && !rx_empty;
    assign s_axis_tready = !rx_full;
    assign clr         = (wr_en && addr == ADDR_STATUS) ? wr_data : 8'h00;
    assign txov_next   = (wr_tx && !tx_accept) || (txov && !clr[ST_TXOV]);
    assign rxovr_next  = rx_overrun_error || (rxovr && !clr[ST_RXOVR]);
    assign ferr_next   = rx_frame_error || (ferr && !clr[ST_FERR]);
    assign ctrl_next   = (wr_en && addr == ADDR_CTRL) ? wr_data[2:0] : ctrl;
    assign status      = {1'b0, tx_busy, ferr, rxovr, txov, rx_full, !rx_empty, !m_axis_tvalid};

    uart_sfr_bridge_rx_fifo #(.DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_data  (s_axis_tdata),
        .pop        (pop),
        .pop_data   (rx_data),
        .empty      (rx_empty),
        .full       (rx_full),
        .avail_next (rxa_next)
    );

    // Read mux sees pre-write state, so a simultaneous write never leaks into the read
    always_comb begin
        rd_mux = 8'h00;
        case (addr)
            ADDR_RCREG:   rd_mux = rx_empty ? 8'h00 : rx_data;
            ADDR_STATUS:  rd_mux = status;
            ADDR_CTRL:    rd_mux = {5'b0, ctrl};
            ADDR_PRESC_L: rd_mux = prescale[7:0];
            ADDR_PRESC_H: rd_mux = prescale[15:8];
            default:      rd_mux = 8'h00;
        endcase
    end

    // Registers; irq is built from next-state values so it tracks the state one cycle after an event
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data       <= 8'h00;
            irq           <= 1'b0;
            m_axis_tdata  <= 8'h00;
            m_axis_tvalid <= 1'b0;
            prescale      <= PRESCALE_RST;
            ctrl          <= 3'b000;
            txov          <= 1'b0;
            rxovr         <= 1'b0;
            ferr          <= 1'b0;
        end else begin
            if (rd_en) rd_data <= rd_mux;
            if (tx_accept) m_axis_tdata <= wr_data;
            m_axis_tvalid <= tvalid_next;
            if (wr_en && addr == ADDR_PRESC_L) prescale[7:0] <= wr_data;
            if (wr_en && addr == ADDR_PRESC_H) prescale[15:8] <= wr_data;
            ctrl  <= ctrl_next;
            txov  <= txov_next;
            rxovr <= rxovr_next;
            ferr  <= ferr_next;
            irq   <= (ctrl_next[CT_TXIE] && !tvalid_next) || (ctrl_next[CT_RXIE] && rxa_next)
                     || (ctrl_next[CT_ERRIE] && (txov_next || rxovr_next || ferr_next));
        end
    end
endmodule

// File: tb/tb_uart_sfr_bridge.sv
// tb_uart_sfr_bridge: register vectors, directed corner sequences and random traffic against a queue-based model
module tb_uart_sfr_bridge;
`ifdef UART_SFR_BRIDGE_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_data;
    logic        irq;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [7:0]  s_axis_tdata = 8'h00;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        tx_busy = 1'b0;
    logic        rx_overrun_error = 1'b0;
    logic        rx_frame_error = 1'b0;
    logic [15:0] prescale;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0]  q[$];
    logic        tx_pend, txov, rxovr, ferr;
    logic [7:0]  tx_byte;
    logic [2:0]  ctrl;
    logic [15:0] presc;

    typedef struct {
        logic [2:0] a;
        logic [7:0] d;
        logic [7:0] e;
    } vec_t;
    vec_t vecs[7];

    uart_sfr_bridge #(.PRESCALE_RST(16'd2), .RX_FIFO_DEPTH(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .addr             (addr),
        .wr_en            (wr_en),
        .wr_data          (wr_data),
        .rd_en            (rd_en),
        .rd_data          (rd_data),
        .irq              (irq),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .tx_busy          (tx_busy),
        .rx_overrun_error (rx_overrun_error),
        .rx_frame_error   (rx_frame_error),
        .prescale         (prescale)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        tx_pend = 1'b0;
        tx_byte = 8'h00;
        txov = 1'b0;
        rxovr = 1'b0;
        ferr = 1'b0;
        ctrl = 3'b000;
        presc = 16'd2;
    endtask

    function automatic logic [7:0] model_read();
        case (addr)
            3'd1: return q.size() != 0 ? q[0] : 8'h00;
            3'd2: return {1'b0, tx_busy, ferr, rxovr, txov, q.size() == CAP, q.size() != 0, !tx_pend};
            3'd3: return {5'b0, ctrl};
            3'd4: return presc[7:0];
            3'd5: return presc[15:8];
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic model_irq();
        return (ctrl[0] && !tx_pend) || (ctrl[1] && q.size() != 0) || (ctrl[2] && (txov || rxovr || ferr));
    endfunction

    // Apply the currently driven inputs for one clock, advance the model, compare, then drop strobes
    task automatic step();
        logic [7:0] exp_rd, clr;
        logic hs, wtx, acc, pop, push;
        check("s_axis_tready", s_axis_tready, q.size() < CAP);
        exp_rd = model_read();
        hs   = tx_pend && m_axis_tready;
        wtx  = wr_en && addr == 3'd0;
        acc  = wtx && (!tx_pend || hs);
        pop  = rd_en && addr == 3'd1 && q.size() != 0;
        push = s_axis_tvalid && q.size() < CAP;
        clr  = (wr_en && addr == 3'd2) ? wr_data : 8'h00;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(s_axis_tdata);
        if (hs) tx_pend = 1'b0;
        if (acc) begin
            tx_pend = 1'b1;
            tx_byte = wr_data;
        end
        txov  = (wtx && !acc) || (txov && !clr[3]);
        rxovr = rx_overrun_error || (rxovr && !clr[4]);
        ferr  = rx_frame_error || (ferr && !clr[5]);
        if (wr_en && addr == 3'd3) ctrl = wr_data[2:0];
        if (wr_en && addr == 3'd4) presc[7:0] = wr_data;
        if (wr_en && addr == 3'd5) presc[15:8] = wr_data;
        tick();
        if (rd_en) check("rd_data", rd_data, exp_rd);
        check("m_axis_tvalid", m_axis_tvalid, tx_pend);
        if (tx_pend) check("m_axis_tdata", m_axis_tdata, tx_byte);
        check("irq", irq, model_irq());
        check("prescale", prescale, presc);
        wr_en = 1'b0;
        rd_en = 1'b0;
        s_axis_tvalid = 1'b0;
        rx_overrun_error = 1'b0;
        rx_frame_error = 1'b0;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
        addr = a;
        wr_data = d;
        wr_en = 1'b1;
        step();
    endtask

    task automatic bus_rd(input logic [2:0] a);
        addr = a;
        rd_en = 1'b1;
        step();
    endtask

    task automatic rx_beat(input logic [7:0] d);
        s_axis_tdata = d;
        s_axis_tvalid = 1'b1;
        step();
    endtask

    initial begin
        vecs[0] = '{3'd3, 8'hFF, 8'h07};
        vecs[1] = '{3'd3, 8'h00, 8'h00};
        vecs[2] = '{3'd4, 8'h34, 8'h34};
        vecs[3] = '{3'd5, 8'h12, 8'h12};
        vecs[4] = '{3'd6, 8'hAB, 8'h00};
        vecs[5] = '{3'd7, 8'hCD, 8'h00};
        vecs[6] = '{3'd2, 8'h38, 8'h01};
        model_reset();
        tick();
        tick();
        reset_n = 1'b1;

        check("reset prescale", prescale, 16'h0002);
        check("reset irq", irq, 1'b0);
        check("reset s_axis_tready", s_axis_tready, 1'b1);
        check("reset m_axis_tvalid", m_axis_tvalid, 1'b0);
        check("reset rd_data", rd_data, 8'h00);
        bus_rd(3'd2);
        check("reset STATUS", rd_data, 8'h01);

        for (int i = 0; i < 7; i++) begin
            bus_wr(vecs[i].a, vecs[i].d);
            bus_rd(vecs[i].a);
            check("vector readback", rd_data, vecs[i].e);
        end
        check("prescale after writes", prescale, 16'h1234);

        m_axis_tready = 1'b0;
        bus_wr(3'd0, 8'h55);
        check("tx valid after write", m_axis_tvalid, 1'b1);
        check("tx data after write", m_axis_tdata, 8'h55);
        repeat (4) step();
        bus_wr(3'd0, 8'h66);
        check("tx data held in stall", m_axis_tdata, 8'h55);
        bus_rd(3'd2);
        check("STATUS with TXOV", rd_data, 8'h08);
        bus_wr(3'd2, 8'h08);
        bus_rd(3'd2);
        check("STATUS after TXOV clear", rd_data, 8'h00);
        m_axis_tready = 1'b1;
        step();
        check("tx valid after handshake", m_axis_tvalid, 1'b0);
        m_axis_tready = 1'b0;

        bus_wr(3'd3, 8'h02);
        check("irq idle with RXIE", irq, 1'b0);
        rx_beat(8'h5A);
        check("irq after push", irq, 1'b1);
        bus_rd(3'd1);
        check("RCREG pop", rd_data, 8'h5A);
        check("irq after pop", irq, 1'b0);
        bus_rd(3'd1);
        check("RCREG empty read", rd_data, 8'h00);

        for (int i = 0; i < CAP; i++) rx_beat(8'h10 + 8'(i));
        check("tready when full", s_axis_tready, 1'b0);
        bus_rd(3'd2);
        check("STATUS when full", rd_data, 8'h07);
        bus_rd(3'd1);
        check("first pop when full", rd_data, 8'h10);
        for (int k = 0; k < CAP + 3; k++) begin
            s_axis_tdata = 8'hC0 + 8'(k);
            s_axis_tvalid = 1'b1;
            addr = 3'd1;
            rd_en = 1'b1;
            step();
        end

        bus_wr(3'd0, 8'h77);
        rx_beat(8'h21);
        rx_beat(8'h22);
        bus_rd(3'd2);
        #3;
        reset_n = 1'b0;
        #1;
        check("async rst m_axis_tvalid", m_axis_tvalid, 1'b0);
        check("async rst m_axis_tdata", m_axis_tdata, 8'h00);
        check("async rst s_axis_tready", s_axis_tready, 1'b1);
        check("async rst irq", irq, 1'b0);
        check("async rst rd_data", rd_data, 8'h00);
        check("async rst prescale", prescale, 16'h0002);
        model_reset();
        tick();
        reset_n = 1'b1;
        bus_rd(3'd2);
        check("STATUS after async rst", rd_data, 8'h01);

        for (int i = 0; i < 600; i++) begin
            int op;
            op = int'($urandom_range(0, 7));
            s_axis_tvalid = 1'($urandom_range(0, 1));
            s_axis_tdata = 8'($urandom);
            m_axis_tready = ($urandom_range(0, 2) == 0);
            tx_busy = 1'($urandom_range(0, 1));
            rx_overrun_error = ($urandom_range(0, 15) == 0);
            rx_frame_error = ($urandom_range(0, 15) == 0);
            wr_data = 8'($urandom);
            case (op)
                1, 2: begin addr = 3'($urandom_range(1, 7)); rd_en = 1'b1; end
                3: begin addr = 3'd0; wr_en = 1'b1; end
                4: begin addr = 3'd2; wr_en = 1'b1; end
                5: begin addr = 3'd3; wr_en = 1'b1; end
                6: begin addr = 3'($urandom_range(4, 7)); wr_en = 1'b1; end
                7: begin addr = 3'($urandom_range(2, 5)); wr_en = 1'b1; rd_en = 1'b1; end
                default: addr = 3'd1;
            endcase
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_sfr_bridge.md
# uart_sfr_bridge

CPU-side register bridge that sits on the opposite end of the UART's AXI-stream ports from the serial line. It turns PIC special-function-register writes and reads into transmit-stream beats and receive-stream pops. It buffers received bytes, keeps sticky error flags, holds the baud prescale register and raises an interrupt request. It connects the RISC16F84 core's peripheral bus to the `uart` module's `input_axis_*`, `output_axis_*`, status and `prescale` ports.

## Interface
Parameters:
- `PRESCALE_RST`, 16'd2: reset value of the prescale register.
- `RX_FIFO_DEPTH`, 4: receive FIFO depth, power of two, ≥2. Used only with `UART_SFR_BRIDGE_RX_FIFO_EN`.

Ports:
- `clk` in 1: single clock for all logic.
- `reset_n` in 1: asynchronous, active-low reset.
- `addr` in 3: register select. 0 TXREG, 1 RCREG, 2 STATUS, 3 CTRL, 4 PRESC_L, 5 PRESC_H; 6–7 read 0x00, writes ignored.
- `wr_en` in 1: write strobe, one cycle.
- `wr_data` in 8: write data.
- `rd_en` in 1: read strobe, one cycle.
- `rd_data` out 8: registered read data.
- `irq` out 1: registered interrupt request.
- `m_axis_tdata` out 8: byte to the UART transmitter.
- `m_axis_tvalid` out 1: transmit byte valid.
- `m_axis_tready` in 1: transmitter ready.
- `s_axis_tdata` in 8: byte from the UART receiver.
- `s_axis_tvalid` in 1: received byte valid.
- `s_axis_tready` out 1: bridge can accept a received byte.
- `tx_busy` in 1: UART transmitter busy, live status.
- `rx_overrun_error` in 1: UART receiver overrun pulse.
- `rx_frame_error` in 1: UART receiver framing-error pulse.
- `prescale` out 16: baud prescale register, driven to the UART.

## Operation
Reset values:
- `rd_data`=0, `irq`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0.
- `s_axis_tready`=1, `prescale`=`PRESCALE_RST`.
- CTRL=0, all sticky flags=0, RX buffer empty.

TX path:
- One-entry holding register.
- A TXREG write is accepted when the holding register is empty, or when a handshake (`m_axis_tvalid && m_axis_tready`) completes in the same cycle.
- An accepted write loads `m_axis_tdata` and sets `m_axis_tvalid`.
- A TXREG write that is not accepted is dropped and sets sticky TXOV.
- `m_axis_tvalid` stays high, with `m_axis_tdata` stable, until the handshake completes.

RX path:
- `s_axis_tready` = !rx_full, taken from a register only. No combinational path from the read strobe.
- A beat is pushed on `s_axis_tvalid && s_axis_tready`.
- An RCREG read with data present returns the oldest byte and pops it.
- An RCREG read with the buffer empty returns 0x00, does not pop, and leaves state unchanged.
- Push and pop in the same cycle are both performed; occupancy is unchanged.

STATUS (read):
- b0 TXE: holding register empty.
- b1 RXA: RX not empty.
- b2 RXF: RX full.
- b3 TXOV: sticky.
- b4 RXOVR: sticky, set by `rx_overrun_error`.
- b5 FERR: sticky, set by `rx_frame_error`.
- b6 TXBUSY: live `tx_busy`.
- b7: 0.

STATUS (write):
- Writing 1 to b3–b5 clears the corresponding flag.
- If a set and a clear hit the same flag in the same cycle, set wins.

CTRL:
- b0 TXIE, b1 RXIE, b2 ERRIE; b7–b3 read 0.

PRESC_L / PRESC_H:
- Each is written and read back independently; `prescale` updates on the following cycle.

Interrupt:
- `irq` next = (TXIE & TXE) | (RXIE & RXA) | (ERRIE & (TXOV|RXOVR|FERR)).

Bus rule:
- If `wr_en` and `rd_en` are both high, the write takes effect and the read also returns the pre-write value.

## Timing
- Read latency is 1: `rd_data` is valid on the cycle after `rd_en` and holds until the next read.
- The RCREG pop takes effect in the `rd_en` cycle; STATUS read in the next cycle reflects it.
- TXREG write in cycle N gives `m_axis_tvalid`=1 in cycle N+1, at the earliest.
- RX push in cycle N gives RXA=1 and `irq` (if enabled) in cycle N+1.
- After an RX pop frees a full buffer, `s_axis_tready` rises in cycle N+1.
- An asserted `reset_n` mid-transfer drops `m_axis_tvalid` immediately, flushes RX and discards any pending byte.

## Configuration
- `UART_SFR_BRIDGE_RX_FIFO_EN` defined: RX buffer is an `RX_FIFO_DEPTH`-entry circular FIFO with wrapping pointers and an occupancy count. RXF = count==`RX_FIFO_DEPTH`.
- Undefined: single-entry holding register; RXF == RXA. `RX_FIFO_DEPTH` is ignored.

## Structure
- Package `uart_sfr_bridge_pkg` holds:
  - register address constants: ADDR_TXREG … ADDR_PRESC_H;
  - STATUS bit indices;
  - CTRL bit indices.
- Sub-module `uart_sfr_bridge_rx_fifo` holds:
  - push/pop, full/empty and data out;
  - both macro variants inside it.
- The top level holds the register decode, TX holding register, sticky flags and irq.

## Test plan
- Reset → STATUS reads 0x01, `prescale`=0x0002, `irq`=0, `s_axis_tready`=1.
- Write TXREG=0x55 with `m_axis_tready` low for 5 cycles, then high → `m_axis_tvalid` held with data 0x55, then drops one cycle after the handshake. A second write during the stall sets TXOV (STATUS=0x08); writing 0x08 to STATUS clears it.
- Loop the bridge through `uart` (rxd=txd, prescale 2), send 0x55 then 0xAA → RCREG reads 0x55 then 0xAA, then 0x00 with RXA=0.
- With RXIE=1, receive 1 byte → `irq`=1 one cycle after the push; read RCREG → `irq`=0 on the following cycle.
- Push `RX_FIFO_DEPTH` bytes (1 without the macro) with no reads → RXF=1 and `s_axis_tready`=0. Pop and push in the same cycle → count unchanged, FIFO order preserved across pointer wrap.
- Assert `reset_n` low while `m_axis_tvalid`=1 with 2 RX bytes buffered → all outputs return to their reset values asynchronously.
